// File: rtl/emio_bus_initiator_if.sv
// Command/response handshake and EMIO pin bundle of the bus initiator.
// master: initiator view; slave: command source plus EMIO responder view.
interface emio_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_last;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [63:0] emio_ps_out;
    logic [63:0] emio_ps_tri;
    logic [63:0] emio_ps_in;

    modport master (
        input  cmd_valid, cmd_op, cmd_last, cmd_addr, cmd_wdata,
        input  emio_ps_in,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output emio_ps_out, emio_ps_tri
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_last, cmd_addr, cmd_wdata,
        output emio_ps_in,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  emio_ps_out, emio_ps_tri
    );
endinterface

// File: rtl/emio_bus_initiator.sv
// PL-side initiator for the EMIO register-bus handshake (read/write/block write).
// Ports: sysclk, reset (sync, active-low), bus (cmd/rsp handshake + emio_ps_out/tri/in).
module emio_bus_initiator #(
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic                 sysclk,
    input  logic                 reset,
    emio_bus_initiator_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, SETUP, REQ, CAPTURE, RELEASE,
        BLK_WORD, BLK_LOW, BLK_HOLD, BLK_SET, BLK_CLOSE
    } state_t;

    localparam logic [9:0] TO_M1 = 10'(TIMEOUT - 1);
    localparam logic [9:0] SU_M1 = 10'(SETUP_CYC - 1);

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] done_sr, grant_sr;
    logic        done_s, grant_s;
    logic [9:0]  cnt;
    logic [31:0] wdata;
    logic [15:0] addr;
    logic        rd_mode, is_read, blk, last;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        acc, bad, wait_st, wait_ok, abort;
    logic        req_bus, reg_wen, blk_wstart, blk_wen;
    logic        unused_in;

    assign unused_in = ^{bus.emio_ps_in[63:55], bus.emio_ps_in[53:50],
                         bus.emio_ps_in[48:32]};

    assign done_s  = done_sr[SYNC_STAGES-1];
    assign grant_s = grant_sr[SYNC_STAGES-1];

    assign bus.cmd_ready = (state == IDLE) || (state == BLK_HOLD);
    assign acc = bus.cmd_valid && bus.cmd_ready;
    // Ops that do not fit the current bus phase are answered with an error
    // and leave the bus untouched.
    assign bad = acc && (((state == IDLE) && (bus.cmd_op == 2'd3)) ||
                         ((state == BLK_HOLD) && (bus.cmd_op != 2'd3)));

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            done_sr  <= '0;
            grant_sr <= '0;
        end else begin
            done_sr[0]  <= bus.emio_ps_in[49];
            grant_sr[0] <= bus.emio_ps_in[54];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                done_sr[i]  <= done_sr[i-1];
                grant_sr[i] <= grant_sr[i-1];
            end
        end
    end

    // State register
    always_ff @(posedge sysclk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; abort fires when a wait outlives the timeout
    always_comb begin
        wait_st = 1'b1;
        wait_ok = 1'b0;
        unique case (state)
            REQ:       wait_ok = blk ? grant_s : done_s;
            RELEASE:   wait_ok = !done_s && !grant_s;
            BLK_WORD:  wait_ok = done_s;
            BLK_LOW:   wait_ok = !done_s;
            BLK_CLOSE: wait_ok = !grant_s;
            default:   wait_st = 1'b0;
        endcase
        abort = wait_st && !wait_ok && (cnt >= TO_M1);

        state_nx = state;
        unique case (state)
            IDLE:      if (acc && !bad) state_nx = SETUP;
            SETUP:     if (cnt >= SU_M1) state_nx = REQ;
            REQ:       if (wait_ok) state_nx = blk ? BLK_WORD : CAPTURE;
            CAPTURE:   state_nx = RELEASE;
            RELEASE:   if (wait_ok) state_nx = IDLE;
            BLK_WORD:  if (wait_ok) state_nx = BLK_LOW;
            BLK_LOW:   if (wait_ok) state_nx = last ? BLK_CLOSE : BLK_HOLD;
            BLK_HOLD:  if (acc && !bad) state_nx = BLK_SET;
            BLK_SET:   state_nx = BLK_WORD;
            BLK_CLOSE: if (wait_ok) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Bus control outputs decoded from state
    always_comb begin
        req_bus    = 1'b0;
        reg_wen    = 1'b0;
        blk_wstart = 1'b0;
        blk_wen    = 1'b0;
        unique case (state)
            SETUP: blk_wstart = blk;
            REQ: begin
                req_bus    = 1'b1;
                reg_wen    = !blk && !is_read;
                blk_wstart = blk;
            end
            BLK_WORD: begin
                req_bus    = 1'b1;
                reg_wen    = 1'b1;
                blk_wen    = 1'b1;
                blk_wstart = 1'b1;
            end
            BLK_LOW, BLK_HOLD, BLK_SET: begin
                req_bus    = 1'b1;
                blk_wstart = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: command latch, wait counter, response
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cnt       <= '0;
            wdata     <= '0;
            addr      <= '0;
            rd_mode   <= 1'b1;
            is_read   <= 1'b0;
            blk       <= 1'b0;
            last      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (state_nx != state)   cnt <= '0;
            else if (cnt != 10'h3FF) cnt <= cnt + 10'd1;

            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            if (state == IDLE && acc && !bad) begin
                wdata   <= bus.cmd_wdata;
                addr    <= bus.cmd_addr;
                rd_mode <= (bus.cmd_op == 2'd0);
                is_read <= (bus.cmd_op == 2'd0);
                blk     <= (bus.cmd_op == 2'd2);
                last    <= bus.cmd_last;
            end else if (state == BLK_HOLD && acc && !bad) begin
                wdata <= bus.cmd_wdata;
                last  <= bus.cmd_last;
            end else if (state != IDLE && state_nx == IDLE) begin
                wdata <= '0;
                addr  <= '0;
            end

            if (state == CAPTURE)
                rsp_rdata <= is_read ? bus.emio_ps_in[31:0] : 32'h0;

            if (bad || abort) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (state == RELEASE && wait_ok) begin
                rsp_valid <= 1'b1;
            end else if (state == BLK_LOW && wait_ok) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.busy      = (state != IDLE);

    assign bus.emio_ps_out = {11'h0, blk_wen, blk_wstart, reg_wen, 1'b0,
                              req_bus, addr, wdata};
    // Data lanes face the initiator only during reads; control lanes driven
    assign bus.emio_ps_tri = {11'h7FF, 3'b000, 1'b1, 17'h0, {32{rd_mode}}};
endmodule

// File: tb/tb_emio_bus_initiator.sv
// Self-checking bench for emio_bus_initiator with a behavioural EMIO responder.
// Expected responses are queued at command issue and popped on rsp_valid.
module tb_emio_bus_initiator;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    emio_bus_initiator_if bus ();

    emio_bus_initiator #(
        .SETUP_CYC(2), .SYNC_STAGES(2), .TIMEOUT(15)
    ) dut (
        .sysclk(clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    localparam logic [63:0] TRI_RD = 64'hFFE2_0000_FFFF_FFFF;

    rsp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    wire req_bus    = bus.emio_ps_out[48];
    wire reg_wen    = bus.emio_ps_out[50];
    wire blk_wstart = bus.emio_ps_out[51];
    wire blk_wen    = bus.emio_ps_out[52];

    // Responder model
    logic        grant_r = 1'b0;
    logic        done_r = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          wr_cnt = 0;
    logic [15:0] wr_addr = 16'h0;
    logic [31:0] wr_data = 32'h0;
    int          blk_pulses = 0;
    logic [15:0] blk_addr = 16'h0;
    logic [31:0] words[$];

    assign bus.emio_ps_in = {9'h0, grant_r, 4'h0, done_r, 17'h0,
                             done_r ? rd_val : 32'h0};

    always @(posedge clk) begin
        if (stall) begin
            grant_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            grant_r <= req_bus;
            if (blk_wstart) begin
                if (req_bus && !grant_r) blk_addr <= bus.emio_ps_out[47:32];
                if (blk_wen && !done_r) begin
                    done_r <= 1'b1;
                    blk_pulses++;
                    words.push_back(bus.emio_ps_out[31:0]);
                end else if (!blk_wen) begin
                    done_r <= 1'b0;
                end
            end else if (req_bus && grant_r && !done_r) begin
                done_r <= 1'b1;
                if (reg_wen) begin
                    wr_cnt++;
                    wr_addr = bus.emio_ps_out[47:32];
                    wr_data = bus.emio_ps_out[31:0];
                end
            end else if (!req_bus) begin
                done_r <= 1'b0;
            end
        end
    end

    // Event counters
    int   rsp_pulses = 0;
    int   req_rises = 0;
    int   req_falls = 0;
    logic req_q = 1'b0;
    always @(posedge clk) begin
        if (bus.rsp_valid) rsp_pulses++;
        if (req_bus && !req_q) req_rises++;
        if (!req_bus && req_q) req_falls++;
        req_q = req_bus;
    end

    task automatic send(input logic [1:0] op, input logic lst,
                        input logic [15:0] a, input logic [31:0] d,
                        output bit ok);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_last  = lst;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output rsp_t r, output bit got);
        int n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        got = bus.rsp_valid;
        r = {bus.rsp_err, bus.rsp_rdata};
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!req_bus && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.emio_ps_out !== 64'h0) begin
            failures++;
            $display("FAIL rst_out got=%h exp=0", bus.emio_ps_out);
        end
        checks++;
        if (bus.emio_ps_tri !== TRI_RD) begin
            failures++;
            $display("FAIL rst_tri got=%h exp=%h", bus.emio_ps_tri, TRI_RD);
        end
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_ctl got=%b exp=1000",
                     {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.busy});
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_rdata got=%h exp=0", bus.rsp_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read;
        bit ok, got;
        int n, p0;
        rsp_t r, e;
        rd_val = 32'hDEADBEEF;
        p0 = rsp_pulses;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        send(2'd0, 1'b0, 16'h0010, 32'h0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rd_accept got=0 exp=1"); end
        wait_req(n);
        checks++;
        if (n != 2) begin failures++; $display("FAIL rd_setup got=%0d exp=2", n); end
        checks++;
        if (bus.emio_ps_tri[31:0] !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL rd_tri got=%h exp=ffffffff", bus.emio_ps_tri[31:0]);
        end
        checks++;
        if ({bus.emio_ps_out[47:32], reg_wen} !== {16'h0010, 1'b0}) begin
            failures++;
            $display("FAIL rd_addr got=%h/%b exp=0010/0",
                     bus.emio_ps_out[47:32], reg_wen);
        end
        wait_rsp(r, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rd_rsp got=none exp=rsp_valid");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                failures++;
                $display("FAIL rd_data got=%h exp=%h", r, e);
            end
        end
        checks++;
        if (req_bus !== 1'b0) begin
            failures++;
            $display("FAIL rd_req_low got=%b exp=0", req_bus);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_pulses - p0 != 1) begin
            failures++;
            $display("FAIL rd_once got=%0d exp=1", rsp_pulses - p0);
        end
    endtask

    task automatic test_write;
        bit ok, got;
        int n, p0, w0;
        rsp_t r, e;
        p0 = rsp_pulses;
        w0 = wr_cnt;
        exp_q.push_back({1'b0, 32'h0});
        send(2'd1, 1'b0, 16'h0020, 32'h1234_5678, ok);
        wait_req(n);
        checks++;
        if ({bus.emio_ps_tri[31:0], reg_wen} !== {32'h0, 1'b1}) begin
            failures++;
            $display("FAIL wr_req got=%h/%b exp=0/1",
                     bus.emio_ps_tri[31:0], reg_wen);
        end
        wait_rsp(r, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wr_rsp got=none exp=rsp_valid");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                failures++;
                $display("FAIL wr_data_rsp got=%h exp=%h", r, e);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({wr_cnt - w0, wr_addr, wr_data} !== {32'd1, 16'h0020, 32'h1234_5678}) begin
            failures++;
            $display("FAIL wr_seen got=%0d %h %h exp=1 0020 12345678",
                     wr_cnt - w0, wr_addr, wr_data);
        end
        checks++;
        if (rsp_pulses - p0 != 1) begin
            failures++;
            $display("FAIL wr_once got=%0d exp=1", rsp_pulses - p0);
        end
        checks++;
        if (bus.emio_ps_out !== 64'h0) begin
            failures++;
            $display("FAIL wr_idle got=%h exp=0", bus.emio_ps_out);
        end
    endtask

    task automatic test_block;
        logic [31:0] dat[4];
        bit ok, got;
        int b0, rf0, p0, n;
        rsp_t r, e;
        dat = '{32'hB000_0100, 32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2};
        b0  = blk_pulses;
        rf0 = req_falls;
        p0  = rsp_pulses;
        words.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 32'h0});
            send((i == 0) ? 2'd2 : 2'd3, (i == 3), 16'h0100, dat[i], ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL blk_accept%0d got=0 exp=1", i); end
            wait_rsp(r, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL blk_rsp%0d got=none exp=rsp_valid", i);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (r !== e) begin
                    failures++;
                    $display("FAIL blk_data%0d got=%h exp=%h", i, r, e);
                end
            end
            if (i < 3) begin
                checks++;
                if ({req_bus, blk_wstart, req_falls - rf0} !== {2'b11, 32'd0}) begin
                    failures++;
                    $display("FAIL blk_hold%0d got=%b%b/%0d exp=11/0",
                             i, req_bus, blk_wstart, req_falls - rf0);
                end
            end
            if (i == 1) begin
                exp_q.push_back({1'b1, 32'h0});
                send(2'd0, 1'b0, 16'h0200, 32'h0, ok);
                wait_rsp(r, got);
                e = exp_q.pop_front();
                checks++;
                if (!got || r !== e || !req_bus) begin
                    failures++;
                    $display("FAIL blk_badop got=%b %h req=%b exp=1 %h req=1",
                             got, r, req_bus, e);
                end
            end
        end
        n = 0;
        while (bus.busy && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL blk_close got=busy exp=idle"); end
        checks++;
        if ({blk_pulses - b0, req_falls - rf0, rsp_pulses - p0} !== {32'd4, 32'd1, 32'd5}) begin
            failures++;
            $display("FAIL blk_counts got=%0d/%0d/%0d exp=4/1/5",
                     blk_pulses - b0, req_falls - rf0, rsp_pulses - p0);
        end
        checks++;
        if (words.size() != 4 || blk_addr !== 16'h0100) begin
            failures++;
            $display("FAIL blk_nwords got=%0d @%h exp=4 @0100", words.size(), blk_addr);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (words[i] !== dat[i]) begin
                    failures++;
                    $display("FAIL blk_word%0d got=%h exp=%h", i, words[i], dat[i]);
                end
            end
        end
        checks++;
        if (bus.emio_ps_out !== 64'h0) begin
            failures++;
            $display("FAIL blk_idle got=%h exp=0", bus.emio_ps_out);
        end
    endtask

    task automatic test_timeout;
        bit ok, got;
        int n, m;
        rsp_t r, e;
        stall = 1'b1;
        exp_q.push_back({1'b1, 32'h0});
        send(2'd0, 1'b0, 16'h0030, 32'h0, ok);
        wait_req(n);
        m = 0;
        while (!bus.rsp_valid && m < 100) begin
            if (req_bus) m++;
            @(negedge clk);
        end
        checks++;
        if (m != 15) begin failures++; $display("FAIL to_cycles got=%0d exp=15", m); end
        wait_rsp(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e) begin
            failures++;
            $display("FAIL to_rsp got=%b %h exp=1 %h", got, r, e);
        end
        checks++;
        if ({req_bus, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL to_idle got=%b%b exp=00", req_bus, bus.busy);
        end
        stall = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok, got;
        int n, p0;
        rsp_t r, e;
        rd_val = 32'h5555_AAAA;
        send(2'd0, 1'b0, 16'h0040, 32'h0, ok);
        wait_req(n);
        p0 = rsp_pulses;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.emio_ps_out, bus.busy} !== 65'h0) begin
            failures++;
            $display("FAIL rstmid_out got=%h/%b exp=0/0", bus.emio_ps_out, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (rsp_pulses != p0) begin
            failures++;
            $display("FAIL rstmid_norsp got=%0d exp=0", rsp_pulses - p0);
        end
        rd_val = 32'hCAFE_F00D;
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        send(2'd0, 1'b0, 16'h0044, 32'h0, ok);
        wait_rsp(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e) begin
            failures++;
            $display("FAIL rstmid_read got=%b %h exp=1 %h", got, r, e);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_illegal_op3;
        bit ok, got;
        int r0;
        rsp_t r, e;
        r0 = req_rises;
        exp_q.push_back({1'b1, 32'h0});
        send(2'd3, 1'b1, 16'h0050, 32'h0, ok);
        checks++;
        if ({bus.rsp_valid, bus.rsp_err} !== 2'b11) begin
            failures++;
            $display("FAIL op3_next got=%b%b exp=11", bus.rsp_valid, bus.rsp_err);
        end
        wait_rsp(r, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || r !== e) begin
            failures++;
            $display("FAIL op3_rsp got=%b %h exp=1 %h", got, r, e);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (req_rises != r0 || bus.busy) begin
            failures++;
            $display("FAIL op3_nobus got=%0d/%b exp=0/0", req_rises - r0, bus.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_last  = 1'b0;
        bus.cmd_addr  = 16'h0;
        bus.cmd_wdata = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_block();
        test_timeout();
        test_reset_mid();
        test_illegal_op3();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_empty got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
